cache_ctrl_burst: RTL and testbench

Parametrised successor to the lab cache controller FSM. It sequences CPU requests against a direct-mapped cache and a fixed-latency main memory. It supports multi-word line refill, configurable memory wait states, and a selectable write-through (no-write-allocate) or write-back (write-allocate, dirty eviction) policy. It sits between the CPU request strobe, the cache tag/valid/dirty compare logic, the cache data-array write enable and mux selects, and the memory strobe.

---
 rtl/cache_ctrl_pkg.sv | 25 ++
 rtl/wait_ctr.sv | 32 +++
 rtl/cache_ctrl_burst.sv | 193 +++++++++++++++++++
 tb/tb_cache_ctrl_burst.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and policy constants for the burst cache controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    EVICT   = 3'd2,
    FILL    = 3'd3,
    WT_MEM  = 3'd4,
    RESPOND = 3'd5
  } cc_state_t;

  localparam logic WT = 1'b0;
  localparam logic WB = 1'b1;

  // Counter width for n states, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/wait_ctr.sv
// Memory wait-state down-counter with load, enable and terminal-count flag.
module wait_ctr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_r;

  // Load wins over decrement; the count holds once it reaches zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/cache_ctrl_burst.sv
// Direct-mapped cache controller with burst line refill, memory wait states
// and a write-through or write-back policy selected at elaboration.
module cache_ctrl_burst
  import cache_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int LINE_WORDS  = 4,
  parameter int WRITE_BACK  = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              Strobe,
  input  logic                              DRW,
  input  logic                              M,
  input  logic                              V,
  input  logic                              D,
  output logic                              DReady,
  output logic                              W,
  output logic                              WSel,
  output logic                              RSel,
  output logic                              MStrobe,
  output logic                              MRW,
  output logic                              WbSel,
  output logic                              SetDirty,
  output logic                              ClrDirty,
  output logic [cnt_width(LINE_WORDS)-1:0]  WordIdx
);

  localparam int             CW        = cnt_width(WAIT_CYCLES);
  localparam int             IW        = cnt_width(LINE_WORDS);
  localparam logic [CW-1:0]  WAIT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [IW-1:0]  LAST_WORD = IW'(LINE_WORDS - 1);
  localparam logic           WB_MODE   = (WRITE_BACK != 0) ? WB : WT;

  cc_state_t     state_r, state_s;
  logic          req_wr_r;
  logic [IW-1:0] word_r;
  logic          ctr_load_s, ctr_en_s, word_inc_s;
  logic [CW-1:0] wait_cnt_s;
  logic          wait_tc_s, first_s, hit_s;

  wait_ctr #(.WIDTH(CW)) u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load_s),
    .load_val (WAIT_LOAD),
    .en       (ctr_en_s),
    .count    (wait_cnt_s),
    .tc       (wait_tc_s)
  );

  // A word's first cycle is the one right after the counter was loaded.
  assign first_s = (wait_cnt_s == WAIT_LOAD);
  assign hit_s   = M & V;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request type is captured only when a new request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_wr_r <= 1'b0;
    end else if ((state_r == IDLE) && Strobe) begin
      req_wr_r <= DRW;
    end else begin
      req_wr_r <= req_wr_r;
    end
  end

  // Burst word counter wraps so a fill after an eviction starts at word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r <= {IW{1'b0}};
    end else if (word_inc_s) begin
      word_r <= (word_r == LAST_WORD) ? {IW{1'b0}} : word_r + IW'(1);
    end else begin
      word_r <= word_r;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s    = state_r;
    ctr_load_s = 1'b0;
    ctr_en_s   = 1'b0;
    word_inc_s = 1'b0;
    DReady     = 1'b0;
    W          = 1'b0;
    WSel       = 1'b0;
    RSel       = 1'b0;
    MStrobe    = 1'b0;
    MRW        = 1'b0;
    WbSel      = 1'b0;
    SetDirty   = 1'b0;
    ClrDirty   = 1'b0;
    WordIdx    = {IW{1'b0}};
    case (state_r)
      IDLE: begin
        if (Strobe) begin
          state_s = LOOKUP;
        end else begin
          state_s = IDLE;
        end
      end
      LOOKUP: begin
        if (!req_wr_r && hit_s) begin
          DReady  = 1'b1;
          state_s = IDLE;
        end else if (req_wr_r && (WB_MODE == WT)) begin
          W          = hit_s;
          MStrobe    = 1'b1;
          MRW        = 1'b1;
          ctr_load_s = 1'b1;
          state_s    = WT_MEM;
        end else if (req_wr_r && hit_s) begin
          W        = 1'b1;
          SetDirty = 1'b1;
          DReady   = 1'b1;
          state_s  = IDLE;
        end else begin
          ctr_load_s = 1'b1;
          if ((WB_MODE == WB) && V && D) begin
            state_s = EVICT;
          end else begin
            state_s = FILL;
          end
        end
      end
      EVICT: begin
        MRW     = 1'b1;
        WbSel   = 1'b1;
        MStrobe = first_s;
        WordIdx = word_r;
        if (wait_tc_s) begin
          ctr_load_s = 1'b1;
          word_inc_s = 1'b1;
          if (word_r == LAST_WORD) begin
            state_s = FILL;
          end else begin
            state_s = EVICT;
          end
        end else begin
          ctr_en_s = 1'b1;
        end
      end
      FILL: begin
        MStrobe = first_s;
        WordIdx = word_r;
        if (wait_tc_s) begin
          W          = 1'b1;
          WSel       = 1'b1;
          ClrDirty   = 1'b1;
          word_inc_s = 1'b1;
          if (word_r == LAST_WORD) begin
            state_s = RESPOND;
          end else begin
            ctr_load_s = 1'b1;
          end
        end else begin
          ctr_en_s = 1'b1;
        end
      end
      WT_MEM: begin
        if (wait_tc_s) begin
          DReady  = 1'b1;
          state_s = IDLE;
        end else begin
          ctr_en_s = 1'b1;
        end
      end
      RESPOND: begin
        DReady  = 1'b1;
        state_s = IDLE;
        if (req_wr_r) begin
          W        = 1'b1;
          SetDirty = 1'b1;
        end else begin
          W = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Scoreboard bench: four controller configurations, directed requests with
// hand-computed output traces checked by a monitor whenever an output is active.
module tb_cache_ctrl_burst;

  localparam int P_WT [4] = '{4, 3, 4, 1};
  localparam int P_LW [4] = '{4, 2, 1, 2};
  localparam int P_WB [4] = '{0, 1, 0, 0};

  // Output vector bits: DReady W WSel RSel MStrobe MRW WbSel SetDirty ClrDirty WordIdx[1:0]
  localparam logic [10:0] DR = 11'h400;
  localparam logic [10:0] WE = 11'h200;
  localparam logic [10:0] WS = 11'h100;
  localparam logic [10:0] MS = 11'h040;
  localparam logic [10:0] MW = 11'h020;
  localparam logic [10:0] EB = 11'h010;
  localparam logic [10:0] SD = 11'h008;
  localparam logic [10:0] CD = 11'h004;

  typedef struct {
    int          dut;
    int          cyc;
    logic [10:0] vec;
  } exp_t;

  logic        clk;
  logic [3:0]  rst, strobe, drw, m, v, d;
  logic [10:0] ovec [4];
  int          cyc;
  int          total, bad;
  exp_t        sb [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int IW = (P_LW[g] > 1) ? $clog2(P_LW[g]) : 1;
    logic [IW-1:0] wi;
    logic dr, w, ws, rs, ms, mrw, wb, sd, cd;
    cache_ctrl_burst #(
      .WAIT_CYCLES (P_WT[g]),
      .LINE_WORDS  (P_LW[g]),
      .WRITE_BACK  (P_WB[g])
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .Strobe   (strobe[g]),
      .DRW      (drw[g]),
      .M        (m[g]),
      .V        (v[g]),
      .D        (d[g]),
      .DReady   (dr),
      .W        (w),
      .WSel     (ws),
      .RSel     (rs),
      .MStrobe  (ms),
      .MRW      (mrw),
      .WbSel    (wb),
      .SetDirty (sd),
      .ClrDirty (cd),
      .WordIdx  (wi)
    );
    assign ovec[g] = {dr, w, ws, rs, ms, mrw, wb, sd, cd, 2'(wi)};
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int g, input int c, input logic [10:0] vec);
    exp_t e;
    e.dut = g;
    e.cyc = c;
    e.vec = vec;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Pops one expectation per cycle in which any DUT drives an active output.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (ovec[g][10:2] != 9'd0) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected dut%0d cyc=%0d got=%h", g, cyc, ovec[g]);
          end else begin
            e = sb.pop_front();
            if (e.dut != g || e.cyc != cyc || e.vec !== ovec[g]) begin
              bad++;
              $display("FAIL trace dut%0d cyc=%0d got=%h exp=%h exp_dut%0d exp_cyc=%0d",
                       g, cyc, ovec[g], e.vec, e.dut, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_done();
    exp_t e;
    int   n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing dut%0d cyc=%0d exp=%h", e.dut, e.cyc, e.vec);
    end
    repeat (3) @(posedge clk);
    m = 4'b0000;
    v = 4'b0000;
    d = 4'b0000;
  endtask

  // Issues one request; base is the absolute cycle numbered 0 for this request.
  task automatic req(input int g, input logic wr, input logic mm, input logic vv,
                     input logic dd, output int base);
    @(negedge clk);
    drw[g]    = wr;
    m[g]      = mm;
    v[g]      = vv;
    d[g]      = dd;
    strobe[g] = 1'b1;
    @(posedge clk);
    #1;
    strobe[g] = 1'b0;
    base = cyc - 1;
  endtask

  initial begin
    int b, n;
    clk = 1'b0; cyc = 0; total = 0; bad = 0;
    rst = 4'b1111; strobe = 4'b0000; drw = 4'b0000;
    m = 4'b0000; v = 4'b0000; d = 4'b0000;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) chk($sformatf("reset_dut%0d", g), ovec[g], 11'h000);
    rst = 4'b0000;
    repeat (2) @(posedge clk);

    // Read hit, single-word line: DReady in LOOKUP only.
    req(2, 1'b0, 1'b1, 1'b1, 1'b0, b);
    push(2, b + 1, DR);
    wait_done();

    // Clean read miss, 4 words x 4 waits.
    req(0, 1'b0, 1'b0, 1'b0, 1'b0, b);
    for (int k = 0; k < 4; k++) begin
      push(0, b + 2 + 4 * k, MS | 11'(k));
      push(0, b + 5 + 4 * k, WE | WS | CD | 11'(k));
    end
    push(0, b + 18, DR);
    wait_done();

    // Write-through hit, then miss (no allocate).
    req(0, 1'b1, 1'b1, 1'b1, 1'b0, b);
    push(0, b + 1, WE | MS | MW);
    push(0, b + 5, DR);
    wait_done();
    req(0, 1'b1, 1'b0, 1'b1, 1'b0, b);
    push(0, b + 1, MS | MW);
    push(0, b + 5, DR);
    wait_done();

    // Dirty read miss, write-back, 2 words x 3 waits.
    req(1, 1'b0, 1'b0, 1'b1, 1'b1, b);
    for (int c = 2; c < 8; c++)
      push(1, b + c, MW | EB | 11'((c - 2) / 3) | (((c - 2) % 3 == 0) ? MS : 11'h000));
    push(1, b + 8, MS);
    push(1, b + 10, WE | WS | CD);
    push(1, b + 11, MS | 11'd1);
    push(1, b + 13, WE | WS | CD | 11'd1);
    push(1, b + 14, DR);
    wait_done();

    // Write-back write hit, then write miss with allocate.
    req(1, 1'b1, 1'b1, 1'b1, 1'b0, b);
    push(1, b + 1, WE | SD | DR);
    wait_done();
    req(1, 1'b1, 1'b0, 1'b0, 1'b0, b);
    push(1, b + 2, MS);
    push(1, b + 4, WE | WS | CD);
    push(1, b + 5, MS | 11'd1);
    push(1, b + 7, WE | WS | CD | 11'd1);
    push(1, b + 8, WE | SD | DR);
    wait_done();

    // Single wait state: MStrobe and fill write coincide.
    req(3, 1'b0, 1'b0, 1'b0, 1'b0, b);
    push(3, b + 2, MS | WE | WS | CD);
    push(3, b + 3, MS | WE | WS | CD | 11'd1);
    push(3, b + 4, DR);
    wait_done();

    // Reset during the fill phase of a dirty miss, then a normal clean miss.
    req(1, 1'b0, 1'b0, 1'b1, 1'b1, b);
    for (int c = 2; c < 8; c++)
      push(1, b + c, MW | EB | 11'((c - 2) / 3) | (((c - 2) % 3 == 0) ? MS : 11'h000));
    push(1, b + 8, MS);
    push(1, b + 10, WE | WS | CD);
    repeat (10) @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("reset_midburst", ovec[1], 11'h000);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    wait_done();
    req(1, 1'b0, 1'b0, 1'b0, 1'b0, b);
    push(1, b + 2, MS);
    push(1, b + 4, WE | WS | CD);
    push(1, b + 5, MS | 11'd1);
    push(1, b + 7, WE | WS | CD | 11'd1);
    push(1, b + 8, DR);
    wait_done();

    // Strobe held through a read miss: second request is a hit one cycle after IDLE.
    @(negedge clk);
    drw[0] = 1'b0; m[0] = 1'b0; v[0] = 1'b0; strobe[0] = 1'b1;
    @(posedge clk);
    #1;
    b = cyc - 1;
    for (int k = 0; k < 4; k++) begin
      push(0, b + 2 + 4 * k, MS | 11'(k));
      push(0, b + 5 + 4 * k, WE | WS | CD | 11'(k));
    end
    push(0, b + 18, DR);
    push(0, b + 20, DR);
    repeat (2) @(negedge clk);
    m[0] = 1'b1;
    v[0] = 1'b1;
    n = 0;
    while (cyc != b + 20 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    strobe[0] = 1'b0;
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
